// File: rtl/chip8_ps2_pkg.sv
// Shared PS/2 definitions for the host transmitter (ps2out) and the receiver side:
// the transmitter state encoding, common keyboard command bytes and default timings.
package chip8_ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_ACK,
    ST_WAITIDLE
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;

  // 100 us and 15 ms at a 50 MHz clk
  localparam int PS2_INHIBIT_CYCLES_DEF = 5000;
  localparam int PS2_TIMEOUT_CYCLES_DEF = 750000;

  // Parity bit that makes the byte plus parity hold an odd number of ones
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchroniser for one raw PS/2 line plus a falling-edge detector.
// Flops come out of reset at the idle-high line level so no false edge is seen.
module ps2_sync (
  input  logic clk,
  input  logic res,
  input  logic i_line,
  output logic o_level,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Resynchronise the line and keep one cycle of history for edge detection
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_fall  = r_prev & ~r_sync;

endmodule

// File: rtl/ps2out.sv
// PS/2 host-to-device command transmitter. Inhibits the bus, issues a request-to-send,
// shifts out 8 data bits LSB first, odd parity and stop on device clock falling edges,
// then samples the device ack bit and waits for the bus to return idle.
// Optional watchdog: define PS2OUT_TIMEOUT_EN to abort a stalled frame after
// TIMEOUT_CYCLES with done and ack_err set.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for send, both lines released
// INHIBIT  | clock held low for INHIBIT_CYCLES
// REQ      | start bit (data low), clock released, waiting first edge
// DATA     | shifting cmd bits 0..7 on device falling edges
// PARITY   | parity bit on the line
// STOP     | data released (stop bit), next edge samples the ack
// ACK      | record ack result
// WAITIDLE | wait for both lines high, then pulse done
module ps2out
  import chip8_ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       res,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       send,
  input  logic [7:0] cmd,
  output logic       ready,
  output logic       done,
  output logic       ack_err
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);

  ps2_state_e       r_state;
  ps2_state_e       w_next_state;
  logic [7:0]       r_cmd;
  logic             r_parity;
  logic [2:0]       r_bit_cnt;
  logic [INH_W-1:0] r_inh_cnt;
  logic             r_data_oe;
  logic             r_ack_seen;
  logic             r_ack_err;
  logic             w_clk_lvl;
  logic             w_clk_fall;
  logic             w_data_lvl;
  logic             w_data_fall_unused;
  logic             w_ready;
  logic             w_clk_oe;
  logic             w_done;
  logic             w_timeout;
  logic             w_req_entry;

  ps2_sync u_sync_clk (
    .clk     (clk),
    .res     (res),
    .i_line  (ps2_clk_in),
    .o_level (w_clk_lvl),
    .o_fall  (w_clk_fall)
  );

  // Data edges matter only to the receiver; the transmitter uses the level
  ps2_sync u_sync_data (
    .clk     (clk),
    .res     (res),
    .i_line  (ps2_data_in),
    .o_level (w_data_lvl),
    .o_fall  (w_data_fall_unused)
  );

  assign w_req_entry = (r_state == ST_INHIBIT) && (r_inh_cnt == '0);

`ifdef PS2OUT_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            w_wd_active;

  assign w_wd_active = (r_state != ST_IDLE) && (r_state != ST_INHIBIT);
  assign w_timeout   = w_wd_active && (r_wd_cnt == '0);

  // Watchdog down-counter, restarted on request and on every device clock edge
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_wd_cnt <= '0;
    end else if (w_req_entry || (w_wd_active && w_clk_fall)) begin
      r_wd_cnt <= WD_LOAD;
    end else if (w_wd_active && (r_wd_cnt != '0)) begin
      r_wd_cnt <= r_wd_cnt - 1'b1;
    end
  end
`else
  // Watchdog compiled out: this compare is a constant 0
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  // State register
  always_ff @(posedge clk or posedge res) begin
    if (res) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode and state-derived outputs
  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    w_clk_oe     = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (send) w_next_state = ST_INHIBIT;
      end
      ST_INHIBIT: begin
        w_clk_oe = 1'b1;
        if (r_inh_cnt == '0) w_next_state = ST_REQ;
      end
      ST_REQ:    if (w_clk_fall) w_next_state = ST_DATA;
      ST_DATA:   if (w_clk_fall && (r_bit_cnt == 3'd7)) w_next_state = ST_PARITY;
      ST_PARITY: if (w_clk_fall) w_next_state = ST_STOP;
      ST_STOP:   if (w_clk_fall) w_next_state = ST_ACK;
      ST_ACK:    w_next_state = ST_WAITIDLE;
      ST_WAITIDLE: begin
        if (w_clk_lvl && w_data_lvl) begin
          w_done       = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
    if (w_timeout) begin
      w_done       = 1'b1;
      w_next_state = ST_IDLE;
    end
  end

  // Frame datapath: command latch, inhibit timer, data line drive and ack capture
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_cmd      <= '0;
      r_parity   <= 1'b0;
      r_bit_cnt  <= '0;
      r_inh_cnt  <= '0;
      r_data_oe  <= 1'b0;
      r_ack_seen <= 1'b0;
      r_ack_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_data_oe <= 1'b0;
          if (send) begin
            r_cmd     <= cmd;
            r_parity  <= odd_parity(cmd);
            r_inh_cnt <= INH_LOAD;
            r_ack_err <= 1'b0;
          end
        end
        ST_INHIBIT: begin
          if (r_inh_cnt != '0) r_inh_cnt <= r_inh_cnt - 1'b1;
          else                 r_data_oe <= 1'b1;
        end
        ST_REQ: begin
          if (w_clk_fall) begin
            r_data_oe <= ~r_cmd[0];
            r_bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (w_clk_fall) begin
            if (r_bit_cnt == 3'd7) begin
              r_data_oe <= ~r_parity;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_data_oe <= ~r_cmd[r_bit_cnt + 3'd1];
            end
          end
        end
        ST_PARITY: if (w_clk_fall) r_data_oe <= 1'b0;
        ST_STOP:   if (w_clk_fall) r_ack_seen <= ~w_data_lvl;
        ST_ACK:    r_ack_err <= ~r_ack_seen;
        default: ;
      endcase
      if (w_timeout) begin
        r_data_oe <= 1'b0;
        r_ack_err <= 1'b1;
      end
    end
  end

  assign ps2_clk_oe  = w_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign ready       = w_ready;
  assign done        = w_done;
  assign ack_err     = r_ack_err | w_timeout;

endmodule

// File: tb/tb_ps2out.sv
// Directed bench for ps2out with a simple PS/2 device model on open-collector lines.
// Define PS2OUT_TIMEOUT_EN for both bench and RTL to include the watchdog case.
module tb_ps2out;

  localparam int TB_INHIBIT = 5000;
  localparam int TB_TIMEOUT = 10000;
  localparam int HALF_SLOW  = 2000;  // 12.5 kHz device clock at 50 MHz clk
  localparam int HALF_FAST  = 200;

  logic       clk;
  logic       res;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       send;
  logic [7:0] cmd;
  logic       ready;
  logic       done;
  logic       ack_err;

  logic dev_clk_low;
  logic dev_data_low;

  int n_checks;
  int n_errors;
  int cyc;
  int done_cnt;
  int done_cyc;
  logic last_ack_err;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2out #(
    .INHIBIT_CYCLES (TB_INHIBIT),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clk         (clk),
    .res         (res),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .send        (send),
    .cmd         (cmd),
    .ready       (ready),
    .done        (done),
    .ack_err     (ack_err)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc     = cyc;
      last_ack_err = ack_err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] c);
    @(negedge clk);
    cmd  = c;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
  endtask

  // Device model: waits for request, then clocks up to n_falls cycles.
  // bits[0] = start bit, bits[k] = data line at rising edge k (k = 1..10).
  task automatic dev_frame(input int half, input bit do_ack, input int n_falls,
                           output logic [10:0] bits, output bit seen, output int fall_cyc);
    bits     = 'x;
    seen     = 1'b0;
    fall_cyc = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (ps2_data_oe && !ps2_clk_oe) begin
        seen = 1'b1;
        break;
      end
    end
    if (seen) begin
      bits[0] = ps2_data_in;
      repeat (half) @(negedge clk);
      for (int k = 1; k <= 11; k++) begin
        if (k > n_falls) break;
        dev_clk_low = 1'b1;
        fall_cyc    = cyc;
        repeat (half) @(negedge clk);
        dev_clk_low = 1'b0;
        if (k <= 10) bits[k] = ps2_data_in;
        if (k == 10) dev_data_low = do_ack;
        if (k == 11) dev_data_low = 1'b0;
        repeat (half) @(negedge clk);
      end
    end
  endtask

  task automatic wait_done(input int limit, input int start_cnt, output bit got);
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done_cnt != start_cnt) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic [10:0] bits;
    bit   seen;
    bit   got;
    bit   bad;
    int   fcyc;
    int   inh;
    int   d0;

    n_checks     = 0;
    n_errors     = 0;
    cyc          = 0;
    done_cnt     = 0;
    done_cyc     = 0;
    last_ack_err = 1'b0;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    send         = 1'b0;
    cmd          = 8'h00;
    res          = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_ack_err", ack_err, 0);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    res = 1'b0;
    repeat (3) @(negedge clk);

    // Device clock edges while idle are ignored
    repeat (2) begin
      dev_clk_low = 1'b1;
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (20) @(negedge clk);
    end
    chk("idle_edge_ready", ready, 1);
    chk("idle_edge_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    chk("idle_edge_done", done_cnt, 0);

    // Set-LEDs at 12.5 kHz with ack
    d0 = done_cnt;
    send_cmd(8'hED);
    dev_frame(HALF_SLOW, 1'b1, 11, bits, seen, fcyc);
    chk("ed_request", seen, 1);
    repeat (50) @(negedge clk);
    chk("ed_start", bits[0], 0);
    chk("ed_byte", bits[8:1], 8'hED);
    chk("ed_parity", bits[9], 1);
    chk("ed_stop", bits[10], 1);
    chk("ed_done_cnt", done_cnt - d0, 1);
    chk("ed_ack_err", last_ack_err, 0);
    chk("ed_ready", ready, 1);

    // cmd 00 with no ack; send FF while busy
    d0 = done_cnt;
    @(negedge clk);
    cmd  = 8'h00;
    send = 1'b1;
    inh  = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (i == 0) send = 1'b0;
      if (i == 100) begin
        send = 1'b1;
        cmd  = 8'hFF;
      end
      if (i == 110) send = 1'b0;
      if (ps2_data_oe) break;
      if (ps2_clk_oe) inh++;
    end
    chk("inhibit_cycles", inh, TB_INHIBIT);
    chk("req_clk_released", ps2_clk_oe, 0);
    dev_frame(HALF_FAST, 1'b0, 11, bits, seen, fcyc);
    chk("z_request", seen, 1);
    repeat (20) @(negedge clk);
    chk("z_byte", bits[8:1], 8'h00);
    chk("z_parity", bits[9], 1);
    chk("z_stop", bits[10], 1);
    chk("z_ack_err", last_ack_err, 1);
    bad = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ps2_clk_oe || ps2_data_oe || !ready) bad = 1'b1;
    end
    chk("no_second_frame", bad, 0);
    chk("z_done_cnt", done_cnt - d0, 1);

`ifdef PS2OUT_TIMEOUT_EN
    // Device stops clocking after bit 3; F4 has bit 3 = 0 so data is held low
    d0 = done_cnt;
    send_cmd(8'hF4);
    dev_frame(HALF_FAST, 1'b1, 4, bits, seen, fcyc);
    chk("to_request", seen, 1);
    chk("to_data_held", ps2_data_oe, 1);
    wait_done(TB_TIMEOUT + 1000, d0, got);
    chk("to_done_seen", got, 1);
    // two extra cycles of synchroniser latency from line to detected edge
    chk("to_latency", done_cyc - fcyc, TB_TIMEOUT + 2);
    chk("to_ack_err", last_ack_err, 1);
    @(negedge clk);
    chk("to_released", {ps2_clk_oe, ps2_data_oe}, 0);
    chk("to_ready", ready, 1);
    chk("to_done_cnt", done_cnt - d0, 1);
`endif

    // Reset with bit 4 on the line (ED bit 4 = 0, so data is pulled low)
    d0 = done_cnt;
    send_cmd(8'hED);
    dev_frame(HALF_FAST, 1'b1, 5, bits, seen, fcyc);
    chk("rb4_request", seen, 1);
    chk("rb4_data_before", ps2_data_oe, 1);
    res = 1'b1;
    #1;
    chk("rb4_oe_after", {ps2_clk_oe, ps2_data_oe}, 0);
    chk("rb4_ready", ready, 1);
    @(negedge clk);
    res = 1'b0;
    repeat (1000) @(negedge clk);
    chk("rb4_no_done", done_cnt - d0, 0);
    chk("rb4_idle_oe", {ps2_clk_oe, ps2_data_oe}, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL global_time_limit got running exp finished");
    $fatal(1);
  end

endmodule

// File: doc/ps2out.md
PS2OUT -- requirements
Module: ps2out

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, clk cycles ps2 clock is held low before request (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 750000, watchdog limit in clk cycles (15 ms at 50 MHz).
REQ-003 SHALL have port clk, input, 1, system clock; single clock domain.
REQ-004 SHALL have port res, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port ps2_clk_in, input, 1, raw open-collector PS/2 clock line state, asynchronous.
REQ-006 SHALL have port ps2_data_in, input, 1, raw PS/2 data line state, asynchronous.
REQ-007 SHALL have port ps2_clk_oe, output, 1, 1 = pull clock line low.
REQ-008 SHALL have port ps2_data_oe, output, 1, 1 = pull data line low.
REQ-009 SHALL have port send, input, 1, command request, sampled only when ready=1.
REQ-010 SHALL have port cmd, input, 8, command byte (e.g. 8'hED set-LEDs, 8'hFF reset).
REQ-011 SHALL have port ready, output, 1, idle and able to accept send.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when a frame ends, acked or not.
REQ-013 SHALL have port ack_err, output, 1, valid with done; 1 = device returned no ack bit.

Function
REQ-014 SHALL pass ps2_clk_in and ps2_data_in each through a 2-flop synchroniser, then detect a falling edge of the synchronised clock (1-cycle pulse).
REQ-015 SHALL implement states IDLE, INHIBIT, REQ, DATA, PARITY, STOP, ACK, WAITIDLE.
REQ-016 IDLE: ready=1, both oe=0; send=1 latches cmd, computes odd parity, goes to INHIBIT next cycle.
REQ-017 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles, then REQ.
REQ-018 REQ: ps2_data_oe=1 (start bit), ps2_clk_oe=0; first detected falling edge moves to DATA driving bit 0.
REQ-019 DATA: on each falling edge, ps2_data_oe = ~next bit, LSB first; after bit 7 has been held, next falling edge drives the parity bit and enters PARITY.
REQ-020 PARITY: next falling edge releases data (stop bit = 1), enters STOP.
REQ-021 STOP: next falling edge samples synchronised data; low = ack; enters ACK.
REQ-022 ACK: ack_err latched as ~ack; enters WAITIDLE.
REQ-023 WAITIDLE: when synchronised clock and data both high, pulse done for one cycle and return to IDLE.
REQ-024 Parity SHALL make the nine bits cmd plus parity contain an odd number of ones (cmd=8'h00 gives parity 1).
REQ-025 send asserted while ready=0 SHALL be ignored, with no queueing.
REQ-026 A falling edge seen in IDLE or INHIBIT SHALL be ignored; device-to-host traffic is left to the receiver.
REQ-027 cmd changing after acceptance SHALL NOT affect the frame in flight.

Reset
REQ-028 res=1 SHALL force IDLE, ready=1, done=0, ack_err=0, both oe=0, counters and synchronisers cleared to idle-high line values, immediately and asynchronously.
REQ-029 res asserted mid-frame SHALL abort the frame, release both lines, and produce no done pulse.

Configuration
REQ-030 SHALL support macro PS2OUT_TIMEOUT_EN.
REQ-031 With PS2OUT_TIMEOUT_EN defined, a counter SHALL restart on entering REQ and on every falling edge; reaching TIMEOUT_CYCLES in REQ through WAITIDLE SHALL release both lines, pulse done with ack_err=1, and return to IDLE.
REQ-032 Without PS2OUT_TIMEOUT_EN, no watchdog logic SHALL exist; a stalled device holds the block in its current state until res.

Structure
REQ-033 Package chip8_ps2_pkg SHALL hold the state enum, the command constants (8'hED, 8'hFF, 8'hF4) and the default parameter values, shared with the receiver side.
REQ-034 Sub-module ps2_sync SHALL contain the 2-flop synchroniser and the falling-edge detector; one instance per line.

Verification
REQ-035 Bench SHALL send cmd=8'hED with a device model that clocks at 12.5 kHz and acks: captured bits 0,1,0,1,1,0,1,1,1 LSB first with parity 1, then stop 1; done pulses once with ack_err=0.
REQ-036 Bench SHALL send cmd=8'h00: parity bit is 1; clk_oe high for exactly 5000 cycles before data_oe rises.
REQ-037 Bench SHALL run a model that never drives ack: done pulses with ack_err=1.
REQ-038 Bench SHALL assert send=1 with cmd=8'hFF while busy: the frame in flight is unchanged, only one done pulse occurs, and no second frame starts.
REQ-039 Bench SHALL assert res at bit 4 of a frame: both oe drop to 0 in the same cycle, ready=1, and no done pulse follows.
REQ-040 With PS2OUT_TIMEOUT_EN defined and a device that stops clocking after bit 3: done pulses with ack_err=1 TIMEOUT_CYCLES after the last edge, and both lines are released.
